// File: rtl/fsm_seq_pkg.sv
// Shared state encoding and default widths for the FSM stimulus sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsm_seq_pkg;

    localparam int PAT_W_DEF = 16;
    localparam int CNT_W_DEF = $clog2(PAT_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fsm_seq_shreg.sv
// Loadable right-shift pattern register with remaining-bit counter and last-bit flag.
// Latency: load/shift take effect on the next rising edge; flags are combinational.
// Backpressure: none; load has priority over shift.
module fsm_seq_shreg
    import fsm_seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_pat,
    input  logic [CNT_W-1:0] load_len,
    output logic             bit0,
    output logic             cnt_zero,
    output logic             last
);

    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_clamped;

    // Requests longer than the register are cut to the register width.
    assign len_clamped = (int'(load_len) > PAT_W) ? CNT_W'(PAT_W) : load_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            pat_q <= load_pat;
            cnt_q <= len_clamped;
        end else if (shift) begin
            pat_q <= pat_q >> 1;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bit0     = pat_q[0];
    assign cnt_zero = (cnt_q == '0);
    assign last     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fsm_stim_sequencer.sv
// Drives a serial stimulus run into a Moore/Mealy detector and counts its outputs; optional trace via FSM_SEQ_TRACE_EN.
// Latency: done pulses len+2 cycles after the accepted start (len clamped to PAT_W).
// Backpressure: none; start is only honoured in IDLE and is dropped otherwise.
module fsm_stim_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    output logic             fsm_rst_n,
    output logic             x_out,
    input  logic             fsm_moore,
    input  logic             fsm_mealy,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] moore_cnt,
    output logic [CNT_W-1:0] mealy_cnt,
    output logic [PAT_W-1:0] trace
);

    seq_state_t state_q, state_nxt;
    logic       accept;
    logic       in_run;
    logic       sh_bit0, sh_zero, sh_last;

    assign accept = (state_q == IDLE) && start;
    assign in_run = (state_q == RUN);

    fsm_seq_shreg #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift    (in_run),
        .load_pat (pattern),
        .load_len (len),
        .bit0     (sh_bit0),
        .cnt_zero (sh_zero),
        .last     (sh_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        x_out     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                state_nxt = sh_zero ? DONE : RUN;
            end
            RUN: begin
                busy  = 1'b1;
                x_out = sh_bit0;
                if (sh_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered so the detector sees a clean reset for exactly the INIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_rst_n <= 1'b0;
        end else begin
            fsm_rst_n <= (state_nxt != INIT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            moore_cnt <= '0;
            mealy_cnt <= '0;
        end else if (accept) begin
            moore_cnt <= '0;
            mealy_cnt <= '0;
        end else if (in_run) begin
            if (fsm_moore) moore_cnt <= moore_cnt + CNT_W'(1);
            if (fsm_mealy) mealy_cnt <= mealy_cnt + CNT_W'(1);
        end
    end

`ifdef FSM_SEQ_TRACE_EN
    logic [PAT_W-1:0] trace_q;

    // Newest Mealy sample enters at bit 0, older samples move toward the MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_q <= '0;
        end else if (accept) begin
            trace_q <= '0;
        end else if (in_run) begin
            trace_q <= {trace_q[PAT_W-2:0], fsm_mealy};
        end
    end

    assign trace = trace_q;
`else
    assign trace = '0;
`endif

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Bench for fsm_stim_sequencer: table of runs against a small 3-state detector, results checked via a scoreboard.
module tb_fsm_stim_sequencer;

    localparam int PAT_W = 16;
    localparam int CNT_W = 5;

`ifdef FSM_SEQ_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] len = '0;
    logic             fsm_rst_n, x_out, fsm_moore, fsm_mealy, busy, done;
    logic [CNT_W-1:0] moore_cnt, mealy_cnt;
    logic [PAT_W-1:0] trace;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fsm_stim_sequencer #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .fsm_rst_n (fsm_rst_n),
        .x_out     (x_out),
        .fsm_moore (fsm_moore),
        .fsm_mealy (fsm_mealy),
        .busy      (busy),
        .done      (done),
        .moore_cnt (moore_cnt),
        .mealy_cnt (mealy_cnt),
        .trace     (trace)
    );

    // Detector under stimulus: A(0) -> B(1) -> C(2); C stays on x=0, returns to A on x=1.
    // Moore = in C. Mealy = in C, or in B with x=0.
    logic [1:0] det_st = 2'd0;
    always @(posedge clk) begin
        if (!fsm_rst_n)          det_st <= 2'd0;
        else if (det_st == 2'd0) det_st <= 2'd1;
        else if (det_st == 2'd1) det_st <= 2'd2;
        else                     det_st <= x_out ? 2'd0 : 2'd2;
    end
    assign fsm_moore = (det_st == 2'd2);
    assign fsm_mealy = (det_st == 2'd2) || ((det_st == 2'd1) && !x_out);

    typedef struct {
        logic [PAT_W-1:0] pattern;
        logic [CNT_W-1:0] len;
        int               lat;
        logic [CNT_W-1:0] moore;
        logic [CNT_W-1:0] mealy;
        logic [PAT_W-1:0] trace;
    } vec_t;

    vec_t tbl [8];
    vec_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit repulse);
        int               eff;
        bit               seen;
        bit               xbad;
        logic [PAT_W-1:0] xs;
        logic [PAT_W-1:0] mask;
        vec_t             e;
        eff  = (int'(v.len) > PAT_W) ? PAT_W : int'(v.len);
        mask = '0;
        for (int k = 0; k < eff; k++) mask[k] = 1'b1;
        xs   = '0;
        xbad = 1'b0;
        seen = 1'b0;
        sb.push_back(v);
        pattern = v.pattern;
        len     = v.len;
        start   = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            start = repulse && (cyc >= 3) && (cyc <= 5);
            if (cyc == 1) chk("init_rst_low", fsm_rst_n, 1'b0);
            if (cyc == 2) chk("run_rst_high", fsm_rst_n, 1'b1);
            if (x_out) begin
                if (cyc >= 2 && cyc <= eff + 1) xs[cyc-2] = 1'b1;
                else xbad = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("latency", cyc, e.lat);
                chk("moore_cnt", moore_cnt, e.moore);
                chk("mealy_cnt", mealy_cnt, e.mealy);
                chk("trace", trace, TRACE_ON ? e.trace : '0);
                chk("x_seq", {xbad, xs}, {1'b0, e.pattern & mask});
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 1'b0, 1'b1);
            void'(sb.pop_front());
        end else begin
            @(posedge clk);
            #1;
            chk("done_one_cycle", {busy, done}, 2'b00);
            chk("moore_hold", moore_cnt, e.moore);
            chk("mealy_hold", mealy_cnt, e.mealy);
        end
        start = 1'b0;
    endtask

    initial begin
        bit   done_seen;
        vec_t v;

        //          pattern    len     lat moore  mealy  trace
        tbl[0] = '{16'h0007, 5'd3,  5,  5'd1, 5'd1, 16'h0001};
        tbl[1] = '{16'h0000, 5'd3,  5,  5'd1, 5'd2, 16'h0003};
        tbl[2] = '{16'hFFFF, 5'd0,  2,  5'd0, 5'd0, 16'h0000};
        tbl[3] = '{16'hFFFF, 5'd20, 18, 5'd5, 5'd5, 16'h2492};
        tbl[4] = '{16'h00A5, 5'd8,  10, 5'd2, 5'd4, 16'h006C};
        tbl[5] = '{16'h0F0F, 5'd5,  7,  5'd1, 5'd2, 16'h0005};
        tbl[6] = '{16'h0000, 5'd1,  3,  5'd0, 5'd0, 16'h0000};
        tbl[7] = '{16'hFFF0, 5'd16, 18, 5'd6, 5'd7, 16'h7924};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_x", x_out, 1'b0);
        chk("rst_fsm_rst_n", fsm_rst_n, 1'b0);
        chk("rst_cnts", {moore_cnt, mealy_cnt}, '0);
        chk("rst_trace", trace, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_fsm_rst_n", fsm_rst_n, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], 1'b0);
            repeat (2) @(posedge clk);
            #1;
        end

        // Start re-pulsed during RUN must not disturb the run in flight.
        run_vec(tbl[4], 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_queued_run", busy, 1'b0);

        // Reset during the second RUN cycle aborts the run.
        pattern = 16'h0000;
        len     = 5'd10;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_x", x_out, 1'b0);
        chk("abort_fsm_rst_n", fsm_rst_n, 1'b0);
        chk("abort_cnts", {moore_cnt, mealy_cnt}, '0);
        chk("abort_trace", trace, '0);
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (done) done_seen = 1'b1;
        chk("abort_no_done", done_seen, 1'b0);
        chk("abort_release_fsm_rst_n", fsm_rst_n, 1'b1);
        v = tbl[1];
        run_vec(v, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm_stim_sequencer.md
FSM_STIM_SEQUENCER -- requirements
Module: fsm_stim_sequencer

Interface
REQ-001 SHALL have parameter PAT_W, default 16, maximum number of stimulus bits per run.
REQ-002 SHALL have parameter CNT_W, default 5, width of length and result counters; CNT_W SHALL equal clog2(PAT_W+1).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port pattern  input  PAT_W  stimulus bits, applied LSB first, captured on accepted start.
REQ-007 SHALL have port len  input  CNT_W  number of bits to apply, captured on accepted start.
REQ-008 SHALL have port fsm_rst_n  output  1  registered active-low reset driven to the Moore/Mealy detector FSM.
REQ-009 SHALL have port x_out  output  1  serial stimulus bit driven to the FSM x input.
REQ-010 SHALL have port fsm_moore  input  1  FSM Moore output.
REQ-011 SHALL have port fsm_mealy  input  1  FSM Mealy output.
REQ-012 SHALL have port busy  output  1  high in INIT and RUN.
REQ-013 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-014 SHALL have ports moore_cnt and mealy_cnt  output  CNT_W each  number of RUN cycles with the respective FSM output high.
REQ-015 SHALL have port trace  output  PAT_W  captured Mealy bit history (see Configuration).

Function
REQ-016 SHALL implement states IDLE, INIT, RUN, DONE.
REQ-017 IDLE -> INIT when start=1; captures pattern into shift register, len clamped to PAT_W if len > PAT_W, clears moore_cnt, mealy_cnt and trace.
REQ-018 INIT lasts exactly one cycle with fsm_rst_n=0, forcing the FSM to its reset state; INIT -> RUN, or INIT -> DONE when captured len=0.
REQ-019 In RUN, x_out SHALL equal shift register bit 0; on each rising edge the register shifts right by one and the remaining count decrements.
REQ-020 In RUN, fsm_moore and fsm_mealy SHALL be sampled on the same edge that advances x_out (Mealy value corresponds to the current x_out); each counter increments when its input is 1.
REQ-021 RUN -> DONE on the edge consuming the last bit; total latency from accepted start to done pulse = len+2 cycles.
REQ-022 DONE lasts one cycle, done=1, then -> IDLE.
REQ-023 Counters and trace SHALL hold their values from DONE until the next accepted start.
REQ-024 x_out=0 outside RUN; fsm_rst_n=1 outside INIT.
REQ-025 start asserted in INIT, RUN or DONE SHALL be ignored; no queuing.
REQ-026 Counters SHALL not overflow; maximum value PAT_W fits CNT_W.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, x_out=0, fsm_rst_n=0, counters=0, trace=0, shift register=0.
REQ-028 fsm_rst_n SHALL remain 0 while reset=0 and return to 1 on the first clock edge after reset deasserts.
REQ-029 reset asserted mid-RUN SHALL abort the run without a done pulse.

Configuration
REQ-030 Macro FSM_SEQ_TRACE_EN: when defined, each RUN cycle shifts fsm_mealy into trace MSB-first (trace[0] = last sampled bit); when undefined, trace is tied to 0 and no trace register is synthesized.

Structure
REQ-031 Package fsm_seq_pkg SHALL hold the state enumeration (IDLE=2'd0, INIT=2'd1, RUN=2'd2, DONE=2'd3) and default PAT_W/CNT_W constants.
REQ-032 Sub-module fsm_seq_shreg SHALL implement the loadable right-shift pattern register with bit counter and last-bit flag.

Verification
REQ-033 pattern=16'h0007, len=3, start pulse -> x_out 1,1,1 for 3 cycles; done at cycle 5 after start; moore_cnt=1, mealy_cnt=1.
REQ-034 pattern=16'h0000, len=3 -> moore_cnt=1, mealy_cnt=2; with FSM_SEQ_TRACE_EN, trace[2:0]=3'b011.
REQ-035 len=0 -> INIT then DONE; done 2 cycles after start; both counters 0; x_out never 1.
REQ-036 len=20 -> clamped to 16; done 18 cycles after start.
REQ-037 start re-pulsed during RUN -> ignored; results match single-run values.
REQ-038 reset=0 at RUN cycle 2 -> immediate IDLE, all outputs 0, no done; subsequent start runs normally.
